// File: rtl/uart_poller.sv
`default_nettype none
// =============================================================================
// uart_poller : polled byte get/put front end for a memory-mapped UART.
// Optional macro UART_POLL_TIMEOUT_EN bounds failed status polls.   Rev 1.0
// =============================================================================
module uart_poller #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [7:0]  req_data,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_err,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_din,
  input  logic [31:0] uart_dout,
  output logic        uart_en,
  output logic [3:0]  uart_we
);

  localparam logic [31:0] OFS_RX   = 32'h0;
  localparam logic [31:0] OFS_TX   = 32'h4;
  localparam logic [31:0] OFS_STAT = 32'h8;
  localparam logic [7:0]  GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    STAT = 4'd1,
    SW1  = 4'd2,
    SW2  = 4'd3,
    GAP  = 4'd4,
    ACC  = 4'd5,
    AW1  = 4'd6,
    AW2  = 4'd7,
    RESP = 4'd8
  } state_t;

  state_t      state, state_nxt;
  logic        wr_lat;
  logic [7:0]  data_lat;
  logic [7:0]  gap_cnt;
  logic        accept;
  logic        stat_ready;
  logic        timeout_hit;
  logic        en_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] din_nxt;
  logic [3:0]  we_nxt;
  logic        resp_valid_nxt;
  logic [7:0]  resp_data_nxt;
  logic        unused_dout;

  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  // rx_valid is bit 0, tx_full is bit 3 of the status word
  assign stat_ready = wr_lat ? ~uart_dout[3] : uart_dout[0];
  assign unused_dout = ^uart_dout[31:8];

`ifdef UART_POLL_TIMEOUT_EN
  localparam logic [7:0] FAIL_LIMIT = 8'(MAX_POLLS);
  logic [7:0] fail_cnt;

  assign timeout_hit = !stat_ready && ((fail_cnt + 8'd1) == FAIL_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= 8'd0;
      resp_err <= 1'b0;
    end else begin
      if (accept)
        fail_cnt <= 8'd0;
      else if (state == SW2 && !stat_ready)
        fail_cnt <= fail_cnt + 8'd1;
      resp_err <= (state == SW2) && timeout_hit;
    end
  end
`else
  logic [7:0] unused_max_polls;

  assign unused_max_polls = 8'(MAX_POLLS);
  assign timeout_hit      = 1'b0;
  assign resp_err         = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    en_nxt         = 1'b0;
    addr_nxt       = 32'h0;
    din_nxt        = 32'h0;
    we_nxt         = 4'h0;
    resp_valid_nxt = 1'b0;
    resp_data_nxt  = 8'h0;

    unique case (state)
      IDLE: if (accept) state_nxt = STAT;
      STAT: state_nxt = SW1;
      SW1:  state_nxt = SW2;
      SW2: begin
        if (stat_ready)         state_nxt = ACC;
        else if (timeout_hit)   state_nxt = RESP;
        else if (POLL_GAP == 0) state_nxt = STAT;
        else                    state_nxt = GAP;
      end
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = STAT;
      ACC:  state_nxt = wr_lat ? RESP : AW1;
      AW1:  state_nxt = AW2;
      AW2:  state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Bus and response outputs are registered from the state being entered.
    case (state_nxt)
      STAT: begin
        en_nxt   = 1'b1;
        addr_nxt = BASE_ADDR + OFS_STAT;
      end
      ACC: begin
        en_nxt = 1'b1;
        if (wr_lat) begin
          addr_nxt = BASE_ADDR + OFS_TX;
          we_nxt   = 4'hF;
          din_nxt  = {24'h0, data_lat};
        end else begin
          addr_nxt = BASE_ADDR + OFS_RX;
        end
      end
      RESP: begin
        resp_valid_nxt = 1'b1;
        resp_data_nxt  = (state == AW2) ? uart_dout[7:0] : 8'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_en    <= 1'b0;
      uart_addr  <= 32'h0;
      uart_din   <= 32'h0;
      uart_we    <= 4'h0;
      resp_valid <= 1'b0;
      resp_data  <= 8'h0;
      wr_lat     <= 1'b0;
      data_lat   <= 8'h0;
      gap_cnt    <= 8'd0;
    end else begin
      uart_en    <= en_nxt;
      uart_addr  <= addr_nxt;
      uart_din   <= din_nxt;
      uart_we    <= we_nxt;
      resp_valid <= resp_valid_nxt;
      resp_data  <= resp_data_nxt;
      if (accept) begin
        wr_lat   <= req_wr;
        data_lat <= req_data;
      end
      gap_cnt <= (state == GAP && state_nxt == GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

endmodule
`default_nettype wire
